// File: rtl/latency_stat_engine_if.sv
// Echo-arrival handshake and BRAM port-B read bus of the latency stat engine.
interface latency_stat_engine_if #(
    parameter int COUNTER_WIDTH = 40,
    parameter int ADDR_WIDTH    = 13
);
    logic                     echo_valid;
    logic [ADDR_WIDTH-1:0]    echo_tag;
    logic                     echo_ready;
    logic                     bram_reb;
    logic [ADDR_WIDTH-1:0]    bram_rd_addr;
    logic [COUNTER_WIDTH-1:0] bram_rd_data;

    // Producer side: RX engine echo events plus the BRAM read data return.
    modport master (
        output echo_valid, echo_tag, bram_rd_data,
        input  echo_ready, bram_reb, bram_rd_addr
    );

    // Consumer side: the stat engine issuing reads and accepting echoes.
    modport slave (
        input  echo_valid, echo_tag, bram_rd_data,
        output echo_ready, bram_reb, bram_rd_addr
    );
endinterface

// File: rtl/latency_stat_engine.sv
// Latency statistics engine: for every accepted echo it reads the stored send
// timestamp from BRAM, subtracts it from the arrival stamp and folds the result
// into per-run min/max/saturating-sum/count statistics.
module latency_stat_engine #(
    parameter int COUNTER_WIDTH = 40,
    parameter int ADDR_WIDTH    = 13,
    parameter int SUM_WIDTH     = 56,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      start,
    input  logic [CNT_WIDTH-1:0]      target_count,
    input  logic [COUNTER_WIDTH-1:0]  latency_counter,
    latency_stat_engine_if.slave      bus,
    output logic                      lat_valid,
    output logic [COUNTER_WIDTH-1:0]  lat_value,
    output logic [COUNTER_WIDTH-1:0]  lat_min,
    output logic [COUNTER_WIDTH-1:0]  lat_max,
    output logic [SUM_WIDTH-1:0]      lat_sum,
    output logic                      sum_sat,
    output logic [CNT_WIDTH-1:0]      lat_count,
    output logic [1:0]                state_o,
    output logic                      done
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                   state;
    logic [CNT_WIDTH-1:0]     target;
    logic [CNT_WIDTH-1:0]     issued;
    logic [ADDR_WIDTH-1:0]    tag_in;
    logic                     accept;
    logic                     start_acc;
    logic                     retire_last;
    logic                     vld_p0, vld_p1, vld_p2;
    logic [COUNTER_WIDTH-1:0] stamp_p0, stamp_p1, stamp_p2;
    logic [SUM_WIDTH:0]       sum_next;

    // Zero-extended add that clamps to all ones on overflow; the MSB of the
    // result flags that the clamp happened.
    function automatic logic [SUM_WIDTH:0] sat_add(
        input logic [SUM_WIDTH-1:0]     acc,
        input logic [COUNTER_WIDTH-1:0] inc
    );
        logic [SUM_WIDTH:0] wide;
        wide = {1'b0, acc} + {{(SUM_WIDTH + 1 - COUNTER_WIDTH){1'b0}}, inc};
        if (wide[SUM_WIDTH])
            sat_add = {1'b1, {SUM_WIDTH{1'b1}}};
        else
            sat_add = wide;
    endfunction

    assign tag_in         = bus.echo_tag;
    assign bus.echo_ready = (state == RUN) && (issued < target);
    assign accept         = bus.echo_valid && bus.echo_ready;
    assign start_acc      = start && (state == IDLE);
    assign retire_last    = lat_valid && ((lat_count + CNT_WIDTH'(1)) == target);
    assign sum_next       = sat_add(lat_sum, lat_value);
    assign state_o        = state;
    assign done           = (state == DONE);

    // Control pipeline: p0 issues the BRAM read, p1/p2 cover the read latency,
    // then the latency strobe; clear flushes every in-flight valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bram_reb     <= 1'b0;
            bus.bram_rd_addr <= '0;
            vld_p0           <= 1'b0;
            vld_p1           <= 1'b0;
            vld_p2           <= 1'b0;
            lat_valid        <= 1'b0;
            lat_value        <= '0;
        end else if (clear) begin
            bus.bram_reb     <= 1'b0;
            vld_p0           <= 1'b0;
            vld_p1           <= 1'b0;
            vld_p2           <= 1'b0;
            lat_valid        <= 1'b0;
            lat_value        <= '0;
        end else begin
            bus.bram_reb <= accept;
            if (accept)
                bus.bram_rd_addr <= tag_in;
            vld_p0    <= accept;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            lat_valid <= vld_p2;
            // Modular subtraction keeps the result right across counter wrap.
            if (vld_p2)
                lat_value <= stamp_p2 - bus.bram_rd_data;
            else if (start_acc)
                lat_value <= '0;
        end
    end

    // Arrival stamps ride alongside the read; qualified by vld_pN, no reset.
    always_ff @(posedge clk) begin
        stamp_p0 <= latency_counter;
        stamp_p1 <= stamp_p0;
        stamp_p2 <= stamp_p1;
    end

    // Run control: IDLE -> RUN on start, RUN -> DONE once the last sample retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            target <= '0;
            issued <= '0;
        end else if (clear) begin
            state  <= IDLE;
            issued <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target <= target_count;
                        issued <= '0;
                        state  <= (target_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept)
                        issued <= issued + CNT_WIDTH'(1);
                    if (retire_last)
                        state <= DONE;
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Statistics: one update per retired sample, reset by clear or a new run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_min   <= '1;
            lat_max   <= '0;
            lat_sum   <= '0;
            sum_sat   <= 1'b0;
            lat_count <= '0;
        end else if (clear || start_acc) begin
            lat_min   <= '1;
            lat_max   <= '0;
            lat_sum   <= '0;
            sum_sat   <= 1'b0;
            lat_count <= '0;
        end else if (lat_valid && (state == RUN)) begin
            lat_count <= lat_count + CNT_WIDTH'(1);
            if (lat_value < lat_min)
                lat_min <= lat_value;
            if (lat_value > lat_max)
                lat_max <= lat_value;
            lat_sum <= sum_next[SUM_WIDTH-1:0];
            if (sum_next[SUM_WIDTH])
                sum_sat <= 1'b1;
        end
    end
endmodule
